// File: rtl/inbox_writer.sv
// inbox_writer: buffers host bytes in a small FIFO and issues single-cycle INBOX write strobes to hrmcpu.
// Optional feature macro INBOX_WRITER_DELAY_EN: honour the per-byte s_delay countdown before each write.
module inbox_writer #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned DELAY_W    = 10
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic [7:0]          s_data,
    input  logic [DELAY_W-1:0]  s_delay,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                cpu_in_full,
    output logic [7:0]          cpu_in_data,
    output logic                cpu_in_wr,
    output logic                busy,
    output logic [DEPTH_LOG2:0] level
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, GAP} state_t;
    state_t state;

    logic [7:0]            data_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  cnt_zero;

    // Readiness depends only on occupancy, so a same-cycle pop never unblocks a full FIFO.
    assign s_ready = (level != FULL_LEVEL) && !i_rst;
    assign push    = s_valid && s_ready;
    assign pop     = (state == WAIT) && cnt_zero && !cpu_in_full;
    assign busy    = (level != '0) || (state != IDLE);

`ifdef INBOX_WRITER_DELAY_EN
    logic [DELAY_W-1:0] delay_mem [DEPTH];
    logic [DELAY_W-1:0] cnt;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (push) delay_mem[wr_ptr] <= s_delay;
    end

    // The countdown runs regardless of cpu_in_full; full only stalls the final write.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (state == IDLE && level != '0) begin
            cnt <= delay_mem[rd_ptr];
        end else if (state == WAIT && !cnt_zero) begin
            cnt <= cnt - DELAY_W'(1);
        end
    end
`else
    logic unused_delay;
    assign unused_delay = ^s_delay;
    assign cnt_zero     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) data_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cpu_in_wr   <= 1'b0;
            cpu_in_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) state <= WAIT;
                end
                WAIT: begin
                    if (pop) begin
                        state       <= WRITE;
                        cpu_in_wr   <= 1'b1;
                        cpu_in_data <= data_mem[rd_ptr];
                    end
                end
                WRITE: begin
                    cpu_in_wr <= 1'b0;
                    state     <= GAP;
                end
                // GAP lets cpu_in_full reflect the write just issued before the next byte is considered.
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inbox_writer.sv
// tb_inbox_writer: table-driven vectors plus hand sequences; a scoreboard queue holds expected (byte, cycle) writes.
`timescale 1ns/1ps
module tb_inbox_writer;
    localparam int DW = 10;
`ifdef INBOX_WRITER_DELAY_EN
    localparam bit DLY_EN = 1'b1;
`else
    localparam bit DLY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [7:0]    s_data;
    logic [DW-1:0] s_delay;
    logic          s_valid;
    logic          s_ready;
    logic          cpu_in_full;
    logic [7:0]    cpu_in_data;
    logic          cpu_in_wr;
    logic          busy;
    logic [2:0]    level;

    inbox_writer #(.DEPTH_LOG2(2), .DELAY_W(DW)) dut (
        .clk(clk), .i_rst(i_rst), .s_data(s_data), .s_delay(s_delay),
        .s_valid(s_valid), .s_ready(s_ready), .cpu_in_full(cpu_in_full),
        .cpu_in_data(cpu_in_data), .cpu_in_wr(cpu_in_wr), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] data; int cyc; } exp_t;
    exp_t sb[$];

    typedef struct { logic [7:0] data; int dly; int lat_en; int lat_dis; } vec_t;
    vec_t tbl[6];

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_in_wr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", int'(cpu_in_wr), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_data", int'(cpu_in_data), int'(e.data));
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input logic [7:0] d, input int dl, output int t);
        int g;
        @(negedge clk);
        s_data  = d;
        s_delay = DW'(dl);
        s_valid = 1'b1;
        g = 0;
        while (!s_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) begin
            chk("send_ready_timeout", int'(s_ready), 1);
            s_valid = 1'b0;
            t = -1;
        end else begin
            t = cyc + 1;
            @(posedge clk);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk({name, "_pending"}, sb.size(), 0);
        sb.delete();
        chk({name, "_level"}, int'(level), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int prev;
        int exp_c;
        int lat;

        tbl[0] = '{8'h2A, 0,    2,    2};
        tbl[1] = '{8'h05, 7,    9,    2};
        tbl[2] = '{8'hC3, 1,    3,    2};
        tbl[3] = '{8'h00, 2,    4,    2};
        tbl[4] = '{8'hFF, 15,   17,   2};
        tbl[5] = '{8'h5A, 1023, 1025, 2};

        s_data = '0; s_delay = '0; s_valid = 1'b0; cpu_in_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr",      int'(cpu_in_wr),   0);
        chk("rst_data",    int'(cpu_in_data), 0);
        chk("rst_level",   int'(level),       0);
        chk("rst_busy",    int'(busy),        0);
        chk("rst_s_ready", int'(s_ready),     0);
        i_rst = 1'b0;
        #1 chk("s_ready_after_rst", int'(s_ready), 1);

        // Single bytes into an empty FIFO: latency is d+2 with the delay feature, 2 without.
        foreach (tbl[i]) begin
            send(tbl[i].data, tbl[i].dly, t);
            idle_in();
            lat = DLY_EN ? tbl[i].lat_en : tbl[i].lat_dis;
            if (t >= 0) sb.push_back('{tbl[i].data, t + lat});
            wait_drain("vec");
            chk("data_hold", int'(cpu_in_data), int'(tbl[i].data));
        end

        // Back-to-back with s_valid held: writes land no closer than 4 cycles apart.
        prev = -100;
        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 0, t);
            if (t >= 0) begin
                exp_c = (t + 2 > prev + 4) ? t + 2 : prev + 4;
                sb.push_back('{8'(k), exp_c});
                prev = exp_c;
            end
        end
        idle_in();
        wait_drain("b2b");

        // INBOX full held for 20 cycles: no strobe until full is sampled low.
        @(negedge clk);
        cpu_in_full = 1'b1;
        send(8'h77, 3, t);
        idle_in();
        repeat (20) @(negedge clk);
        chk("full_hold_level", int'(level), 1);
        chk("full_hold_busy",  int'(busy),  1);
        cpu_in_full = 1'b0;
        sb.push_back('{8'h77, cyc + 1});
        wait_drain("full");

        // Fill FIFO behind a full INBOX, release one write, then reset during its strobe.
        @(negedge clk);
        cpu_in_full = 1'b1;
        for (int k = 0; k < 4; k++) send(8'(8'hA0 + k), 0, t);
        idle_in();
        chk("fill_level",   int'(level),   4);
        chk("fill_s_ready", int'(s_ready), 0);
        cpu_in_full = 1'b0;
        sb.push_back('{8'hA0, cyc + 1});
        @(negedge clk);
        chk("wr_before_rst", int'(cpu_in_wr), 1);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_wr",      int'(cpu_in_wr),   0);
        chk("midrst_level",   int'(level),       0);
        chk("midrst_busy",    int'(busy),        0);
        chk("midrst_s_ready", int'(s_ready),     0);
        chk("midrst_data",    int'(cpu_in_data), 0);
        sb.delete();
        @(negedge clk);
        i_rst = 1'b0;
        send(8'h10, 0, t);
        idle_in();
        if (t >= 0) sb.push_back('{8'h10, t + 2});
        wait_drain("post_rst");
        chk("post_rst_data", int'(cpu_in_data), 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
